// File: rtl/mux_display_controller.sv
// mux_display_controller: time-multiplexed 7-segment driver with a shadowed load handshake,
// per-digit enables, decimal points, leading-zero blanking and all-off gaps between digits.
module mux_display_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int GAP_CYCLES = 16,
    parameter int ZERO_BLANK = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] DispVals,
    input  logic [NUM_DIGITS-1:0]   DpIn,
    input  logic [NUM_DIGITS-1:0]   DigitEn,
    input  logic                    LoadReq,
    output logic                    LoadAck,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segOut,
    output logic                    dpOut,
    output logic                    FrameTick
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_END = CW'(SCAN_DIV - GAP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    typedef enum logic {SHOW, GAP} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic                           pend_q, pend_d;
    logic [NUM_DIGITS-1:0][3:0]     vals_q, vals_d;
    logic [NUM_DIGITS-1:0]          dp_q, dp_d, en_q, en_d;
    logic [NUM_DIGITS-1:0]          zb;
    logic                           lead, show_end, gap_end, show_d;
    logic [NUM_DIGITS-1:0]          anode_q, anode_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_out_q, dp_out_d;
    logic                           tick_q, tick_d;
    logic                           ack_q, ack_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Output registers are loaded from next-state values so they line up with the FSM state.
    always_comb begin
        show_end = state_q == SHOW && cnt_q == SHOW_END;
        gap_end  = state_q == GAP && cnt_q == GAP_END;
        state_d  = show_end ? GAP : gap_end ? SHOW : state_q;
        cnt_d    = (show_end || gap_end) ? '0 : cnt_q + 1'b1;
        idx_d    = gap_end ? (idx_q == LAST_IDX ? '0 : idx_q + 1'b1) : idx_q;
        tick_d   = state_d == GAP && cnt_d == GAP_END && idx_d == LAST_IDX;
        ack_d    = tick_d && (pend_q || LoadReq);
        pend_d   = !ack_q && (pend_q || LoadReq);
        vals_d   = ack_q ? DispVals : vals_q;
        dp_d     = ack_q ? DpIn : dp_q;
        en_d     = ack_q ? DigitEn : en_q;
    end

    // Scan from the most significant digit; disabled digits neither blank nor stop blanking.
    always_comb begin
        zb   = '0;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zb[i] = ZERO_BLANK != 0 && lead && vals_d[i] == 4'h0 && !dp_d[i] && i != 0;
            lead  = lead && (!en_d[i] || (vals_d[i] == 4'h0 && !dp_d[i]));
        end
    end

    always_comb begin
        show_d   = state_d == SHOW;
        anode_d  = show_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        seg_d    = (show_d && en_d[idx_d] && !zb[idx_d]) ? hex7(vals_d[idx_d]) : 7'h7F;
        dp_out_d = !(show_d && en_d[idx_d] && dp_d[idx_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GAP;
            cnt_q    <= '0;
            idx_q    <= LAST_IDX;
            pend_q   <= 1'b0;
            vals_q   <= '0;
            dp_q     <= '0;
            en_q     <= '0;
            anode_q  <= '1;
            seg_q    <= 7'h7F;
            dp_out_q <= 1'b1;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            vals_q   <= vals_d;
            dp_q     <= dp_d;
            en_q     <= en_d;
            anode_q  <= anode_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
        end
    end

    assign anode     = anode_q;
    assign segOut    = seg_q;
    assign dpOut     = dp_out_q;
    assign FrameTick = tick_q;
    assign LoadAck   = ack_q;
endmodule

// File: tb/tb_mux_display_controller.sv
// tb_mux_display_controller: table vectors, corner sequences and random traffic, all checked
// every cycle against a frame-position model of the display.
module tb_mux_display_controller;
    localparam int N  = 4;
    localparam int SD = 8;
    localparam int G  = 2;
    localparam int FRAME = N * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] DispVals = '0;
    logic [3:0]  DpIn = '0, DigitEn = '0;
    logic        LoadReq = 1'b0;
    logic        LoadAck, dpOut, FrameTick;
    logic [3:0]  anode;
    logic [6:0]  segOut;

    int total = 0, bad = 0;

    int          m_t;
    logic [15:0] m_vals;
    logic [3:0]  m_dp, m_en;
    logic        m_pend;

    typedef struct {
        logic [15:0] vals;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [27:0] seg;
        logic [3:0]  dpo;
    } vec_t;
    vec_t tbl[11];

    mux_display_controller #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GAP_CYCLES(G), .ZERO_BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .DispVals(DispVals), .DpIn(DpIn), .DigitEn(DigitEn),
        .LoadReq(LoadReq), .LoadAck(LoadAck), .anode(anode), .segOut(segOut), .dpOut(dpOut),
        .FrameTick(FrameTick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // A digit is a leading zero if it reads 0 with no dp and every enabled digit above it does too.
    function automatic logic [6:0] want_seg(input int d);
        logic [3:0] nib;
        logic lz;
        nib = m_vals[d*4 +: 4];
        if (!m_en[d]) return 7'h7F;
        lz = d != 0 && nib == 4'h0 && !m_dp[d];
        for (int j = d + 1; j < N; j++)
            if (m_en[j] && (m_vals[j*4 +: 4] != 4'h0 || m_dp[j])) lz = 1'b0;
        return lz ? 7'h7F : hex7(nib);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_vals = '0; m_dp = '0; m_en = '0; m_pend = 1'b0;
    endtask

    // Cycle 0 after reset release is the first gap cycle of the last digit: frame position FRAME-2.
    task automatic step();
        int pos, d;
        logic [3:0] an;
        logic [13:0] want;
        @(posedge clk);
        if (rst_n) begin
            if ((m_t + FRAME - G) % FRAME == FRAME - 1 && m_pend) begin
                m_vals = DispVals; m_dp = DpIn; m_en = DigitEn; m_pend = 1'b0;
            end else m_pend = m_pend | LoadReq;
            m_t++;
        end
        #1;
        pos = (m_t + FRAME - G) % FRAME;
        d   = pos / SD;
        an  = ~(4'b0001 << d);
        want = (pos % SD < SD - G) ? {an, want_seg(d), !(m_en[d] && m_dp[d]), 2'b00}
                                   : {4'hF, 7'h7F, 1'b1, 2'b00};
        want[1] = pos == FRAME - 1;
        want[0] = pos == FRAME - 1 && m_pend;
        check("cycle", 32'({anode, segOut, dpOut, FrameTick, LoadAck}), 32'(want));
        check("onehot", 32'($countones(~anode) <= 1), 32'd1);
    endtask

    initial begin
        int k, acks;
        logic prev;
        logic [15:0] cap, mask;
        tbl[0]  = '{16'h12AF, 4'b0000, 4'b1111, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
        tbl[1]  = '{16'h0030, 4'b0000, 4'b1111, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
        tbl[2]  = '{16'h0005, 4'b0100, 4'b1111, {7'h7F, 7'h40, 7'h40, 7'h12}, 4'b1011};
        tbl[3]  = '{16'h0000, 4'b0000, 4'b1111, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        tbl[4]  = '{16'h8888, 4'b0101, 4'b0101, {7'h7F, 7'h00, 7'h7F, 7'h00}, 4'b1010};
        tbl[5]  = '{16'h0F00, 4'b0000, 4'b0111, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b1111};
        tbl[6]  = '{16'h5000, 4'b0000, 4'b0111, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        tbl[7]  = '{16'h00B0, 4'b0010, 4'b1111, {7'h7F, 7'h7F, 7'h03, 7'h40}, 4'b1101};
        tbl[8]  = '{16'hC9D6, 4'b1000, 4'b1111, {7'h46, 7'h10, 7'h21, 7'h02}, 4'b0111};
        tbl[9]  = '{16'h7E34, 4'b0000, 4'b1111, {7'h78, 7'h06, 7'h30, 7'h19}, 4'b1111};
        tbl[10] = '{16'h0000, 4'b0001, 4'b1110, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};

        #1 rst_n = 1'b0;
        model_reset();
        #2 check("reset", 32'({anode, segOut, dpOut, FrameTick, LoadAck}), 32'({4'hF, 7'h7F, 3'b100}));
        repeat (3) step();
        #3 rst_n = 1'b1;
        #1 check("post_rel_tick0", 32'(FrameTick), 32'd0);
        step();
        check("first_tick", 32'(FrameTick), 32'd1);
        step();
        check("first_show", 32'({anode, segOut, dpOut}), 32'({4'b1110, 7'h7F, 1'b1}));

        for (int i = 0; i < 11; i++) begin
            DispVals = tbl[i].vals; DpIn = tbl[i].dp; DigitEn = tbl[i].en; LoadReq = 1'b1;
            step();
            LoadReq = 1'b0;
            k = 0;
            while (!LoadAck && k < 2 * FRAME + 6) begin step(); k++; end
            check("tbl_ack_tick", 32'({LoadAck, FrameTick}), 32'b11);
            for (int d = 0; d < N; d++) begin
                step();
                check("tbl_anode", 32'(anode), 32'(~(4'b0001 << d) & 4'hF));
                check("tbl_seg", 32'(segOut), 32'(tbl[i].seg[d*7 +: 7]));
                check("tbl_dp", 32'(dpOut), 32'(tbl[i].dpo[d]));
                repeat (SD - 1) step();
            end
        end

        DigitEn = 4'hF; DpIn = 4'h0;
        k = 0;
        while (!FrameTick && k < FRAME + 4) begin step(); k++; end
        check("merge_sync", 32'(FrameTick), 32'd1);
        acks = 0; prev = 1'b0; cap = '0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (prev) check("merge_d0", 32'(segOut), 32'(hex7(cap[3:0])));
            prev = LoadAck;
            acks += int'(LoadAck);
            LoadReq  = i == 2 || i == 9 || i == 16;
            DispVals = 16'($urandom);
            if (LoadAck) cap = DispVals;
        end
        LoadReq = 1'b0;
        check("merge_acks", 32'(acks), 32'd1);

        k = 0;
        while (anode != 4'b1110 && k < FRAME + 4) begin step(); k++; end
        #3 rst_n = 1'b0;
        model_reset();
        #1 check("async_reset", 32'({anode, segOut, dpOut, FrameTick, LoadAck}), 32'({4'hF, 7'h7F, 3'b100}));
        repeat (2) step();
        #3 rst_n = 1'b1;
        #1 check("rel_tick0", 32'(FrameTick), 32'd0);
        step();
        check("rel_tick", 32'(FrameTick), 32'd1);
        step();
        check("rel_show", 32'({anode, segOut, dpOut}), 32'({4'b1110, 7'h7F, 1'b1}));

        for (int i = 0; i < 800; i++) begin
            k = int'($urandom_range(0, 4));
            mask = k == 0 ? 16'hFFFF : k == 1 ? 16'h0FFF : k == 2 ? 16'h00FF : k == 3 ? 16'h000F : 16'h0000;
            DispVals = 16'($urandom) & mask;
            DpIn     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            DigitEn  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            LoadReq  = $urandom_range(0, 15) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_display_controller.md
MUX_DISPLAY_CONTROLLER -- requirements
Module: mux_display_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, 1 to 8.
REQ-002 Parameter SCAN_DIV, default 100000, clock cycles each digit is driven, at least 4.
REQ-003 Parameter GAP_CYCLES, default 16, all-anodes-off cycles between digits, at least 1 and less than SCAN_DIV.
REQ-004 Parameter ZERO_BLANK, default 1, 1 enables leading-zero blanking.
REQ-005 Port clk, input, 1 bit: the single system clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port DispVals, input, 4*NUM_DIGITS bits: hex nibbles; nibble i drives digit i; digit 0 is the rightmost.
REQ-008 Port DpIn, input, NUM_DIGITS bits: decimal point request per digit, active-high.
REQ-009 Port DigitEn, input, NUM_DIGITS bits: per-digit enable; 0 forces that digit blank.
REQ-010 Port LoadReq, input, 1 bit: request to capture DispVals, DpIn and DigitEn.
REQ-011 Port LoadAck, output, 1 bit: one-cycle pulse when the capture completes.
REQ-012 Port anode, output, NUM_DIGITS bits: active-low, at most one bit low at any time.
REQ-013 Port segOut, output, 7 bits: active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-014 Port dpOut, output, 1 bit: active-low decimal point.
REQ-015 Port FrameTick, output, 1 bit: one-cycle pulse at the end of the last digit's gap.

Function
REQ-016 Nibble-to-segment decode shall use the team-standard hex table, e.g. 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; blank shall be 1111111.
REQ-017 A shadow register set (values, dp, enables) shall feed the display; inputs shall never drive outputs directly.
REQ-018 Load handshake, capture timing: LoadReq is sampled every cycle; a pending request is held internally until served; the capture occurs only on the FrameTick cycle.
REQ-019 Load handshake, acknowledge: LoadAck shall pulse on that same FrameTick cycle, and the new values shall be visible starting from digit 0 of the next frame.
REQ-020 Load handshake, request during pending: additional LoadReq pulses while a request is pending shall merge into one capture; the values captured are those present on the FrameTick cycle.
REQ-021 State machine states: SHOW and GAP.
REQ-022 SHOW behaviour: anode[idx]=0, segOut and dpOut from the shadow for digit idx, lasting SCAN_DIV-GAP_CYCLES cycles.
REQ-023 GAP behaviour: anode all 1, segOut 1111111, dpOut 1, lasting GAP_CYCLES cycles; then idx increments and the state returns to SHOW.
REQ-024 Index wrap-around: idx shall wrap from NUM_DIGITS-1 to 0; FrameTick shall fire on the last GAP cycle when idx=NUM_DIGITS-1.
REQ-025 The cycle counter shall be wide enough to hold SCAN_DIV-1 and shall reload to 0 on every state change.
REQ-026 Leading-zero blanking: when ZERO_BLANK=1, a digit whose nibble is 0 and whose more-significant enabled digits are all 0 shall be blank.
REQ-027 Leading-zero blanking exception: digit 0 shall never be zero-blanked.
REQ-028 Leading-zero blanking with decimal point: a digit with its dp set shall stop zero-blanking for itself and for all less-significant digits.
REQ-029 A disabled digit (DigitEn=0) shall show blank segments and an inactive dp, but shall still occupy its SHOW and GAP time slots.
REQ-030 All outputs shall be registered, with no combinational path from any input to any output.
REQ-031 When NUM_DIGITS=1, the block shall still alternate SHOW and GAP, and FrameTick shall fire once per SCAN_DIV cycles.

Reset
REQ-032 While rst_n=0: anode all 1, segOut 1111111, dpOut 1, LoadAck 0, FrameTick 0.
REQ-033 While rst_n=0: state GAP, idx NUM_DIGITS-1, counter 0, shadow values 0, shadow enables 0, pending request cleared.
REQ-034 Assertion of reset mid-frame shall take effect immediately, without waiting for a clock edge.
REQ-035 After rst_n deasserts, the first FrameTick shall occur after GAP_CYCLES cycles; digit 0 SHOW shall begin on the next cycle.

Verification
REQ-036 Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, GAP_CYCLES=2.
REQ-037 Scenario, basic load: DispVals=16'h12AF, DigitEn=1111, LoadReq pulsed mid-frame -> LoadAck coincides with FrameTick; next frame shows anode 1110 with segOut 0001110, then anode 1101 with segOut 0001000, each lasting 6 cycles followed by a 2-cycle all-off gap.
REQ-038 Scenario, zero blanking: DispVals=16'h0030, ZERO_BLANK=1 -> digits 3 and 2 blank; digit 1 shows 0110000; digit 0 shows 1000000.
REQ-039 Scenario, dp stops blanking: DispVals=16'h0005, DpIn=0100 -> digit 2 shows 1000000 with dpOut=0; digit 1 shows 1000000; digit 3 blank.
REQ-040 Scenario, merged loads: three LoadReq pulses within one frame with changing DispVals -> exactly one LoadAck; the captured value equals DispVals on the FrameTick cycle.
REQ-041 Scenario, mid-frame reset: rst_n pulled low during a SHOW slot -> anode 1111 and segOut 1111111 without waiting for a clock edge; after release, FrameTick follows 2 cycles later.
REQ-042 Scenario, invariant check: a checker confirms that across all scenarios anode never has more than one bit low.
